// File: rtl/poly_sample_voice_engine.sv
// Polyphonic sample-playback engine: per tick, reads one SRAM word per active voice and mixes them with saturation.
// Optional feature: define VOICE_LOOP_EN to loop held notes; otherwise each note plays once (one-shot).
//
// state | meaning
// IDLE  | waiting for sample_tick
// SCAN  | latch keycodes, update voices, clear accumulator, pick first voice
// FETCH | hold address READ_LAT cycles per active voice, accumulate on last
// DONE  | present saturated mix, pulse audio_valid
module poly_sample_voice_engine #(
  parameter int NUM_VOICES   = 4,
  parameter int KEY_W        = 8,
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int REGION_SHIFT = 12,
  parameter int NOTE_LEN     = 4096,
  parameter int READ_LAT     = 2
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        sample_tick,
  input  logic [NUM_VOICES*KEY_W-1:0] keycode,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic                        sram_oe,
  input  logic [DATA_W-1:0]           sram_data,
  output logic [DATA_W-1:0]           audio_data,
  output logic                        audio_valid,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic                        busy,
  output logic                        overrun
);

  localparam int ACC_W = DATA_W + $clog2(NUM_VOICES);
  localparam int OFF_W = (NOTE_LEN > 1) ? $clog2(NOTE_LEN) : 1;
  localparam int VID_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;

  state_t                  state, state_nxt;
  logic [KEY_W-1:0]        key_q    [NUM_VOICES];
  logic [OFF_W-1:0]        offset_q [NUM_VOICES];
  logic [KEY_W-1:0]        slot_key [NUM_VOICES];
  logic [NUM_VOICES-1:0]   active_q;
  logic [NUM_VOICES-1:0]   scan_active;
  logic [VID_W-1:0]        cur_q;
  logic [VID_W-1:0]        first_idx, next_idx;
  logic                    first_any, next_any;
  logic [LAT_W-1:0]        lat_cnt;
  logic                    read_last;
  logic signed [ACC_W-1:0] acc_q, acc_sum;

  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  assign acc_sum      = acc_q + ACC_W'($signed(sram_data));
  assign read_last    = (lat_cnt == '0);
  assign busy         = (state != IDLE);
  assign voice_active = active_q;

  // Voice state as it will look after SCAN; a finished voice keeps its key but stays inactive.
  always_comb begin
    scan_active = '0;
    first_any   = 1'b0;
    first_idx   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      slot_key[i] = keycode[i*KEY_W +: KEY_W];
    end
    for (int i = NUM_VOICES-1; i >= 0; i--) begin
      scan_active[i] = (slot_key[i] != '0) && ((slot_key[i] != key_q[i]) || active_q[i]);
      if (scan_active[i]) begin
        first_any = 1'b1;
        first_idx = VID_W'(i);
      end
    end
  end

  always_comb begin
    next_any = 1'b0;
    next_idx = '0;
    for (int i = NUM_VOICES-1; i >= 0; i--) begin
      if (active_q[i] && (VID_W'(i) > cur_q)) begin
        next_any = 1'b1;
        next_idx = VID_W'(i);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sram_oe     = 1'b0;
    sram_addr   = '0;
    audio_valid = 1'b0;
    case (state)
      IDLE:  if (sample_tick) state_nxt = SCAN;
      SCAN:  state_nxt = first_any ? FETCH : DONE;
      FETCH: begin
        sram_oe   = 1'b1;
        sram_addr = (ADDR_W'(key_q[cur_q]) << REGION_SHIFT) + ADDR_W'(offset_q[cur_q]);
        if (read_last) state_nxt = next_any ? FETCH : DONE;
      end
      DONE: begin
        audio_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        key_q[i]    <= '0;
        offset_q[i] <= '0;
      end
      active_q   <= '0;
      cur_q      <= '0;
      lat_cnt    <= '0;
      acc_q      <= '0;
      audio_data <= '0;
      overrun    <= 1'b0;
    end else begin
      if (sample_tick && (state != IDLE)) overrun <= 1'b1;
      case (state)
        SCAN: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (slot_key[i] == '0) begin
              key_q[i]    <= '0;
              offset_q[i] <= '0;
            end else if (slot_key[i] != key_q[i]) begin
              key_q[i]    <= slot_key[i];
              offset_q[i] <= '0;
            end
          end
          active_q <= scan_active;
          acc_q    <= '0;
          cur_q    <= first_idx;
          lat_cnt  <= LAT_W'(READ_LAT-1);
          if (!first_any) audio_data <= '0;
        end
        FETCH: begin
          if (read_last) begin
            acc_q   <= acc_sum;
            cur_q   <= next_idx;
            lat_cnt <= LAT_W'(READ_LAT-1);
            if (offset_q[cur_q] == OFF_W'(NOTE_LEN-1)) begin
`ifdef VOICE_LOOP_EN
              offset_q[cur_q] <= '0;
`else
              offset_q[cur_q] <= '0;
              active_q[cur_q] <= 1'b0;
`endif
            end else begin
              offset_q[cur_q] <= offset_q[cur_q] + OFF_W'(1);
            end
            // Load the output on the edge entering DONE so it lines up with audio_valid.
            if (!next_any) audio_data <= saturate(acc_sum);
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_sample_voice_engine.sv
// Randomised self-checking bench for poly_sample_voice_engine against a per-tick behavioural voice model.
// Honours VOICE_LOOP_EN the same way the design does.
`timescale 1ns/1ps
module tb_poly_sample_voice_engine;
  localparam int NV = 4, KW = 8, AW = 20, DW = 16, RS = 12, NL = 4096, RL = 2;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           sample_tick = 1'b0;
  logic [NV*KW-1:0] keycode = '0;
  logic [AW-1:0]  sram_addr;
  logic           sram_oe;
  logic [DW-1:0]  sram_data;
  logic [DW-1:0]  audio_data;
  logic           audio_valid;
  logic [NV-1:0]  voice_active;
  logic           busy;
  logic           overrun;

  int n_checks = 0;
  int n_pass   = 0;

  int        sram_mode = 0;
  logic [15:0] const_word = '0;

  int  m_key [NV];
  int  m_off [NV];
  bit  m_act [NV];
  bit  m_ovr;
  int  exp_addr[$];
  int  exp_data, exp_a;
  int  obs_first_addr, obs_lat, obs_data;

  poly_sample_voice_engine #(
    .NUM_VOICES(NV), .KEY_W(KW), .ADDR_W(AW), .DATA_W(DW),
    .REGION_SHIFT(RS), .NOTE_LEN(NL), .READ_LAT(RL)
  ) dut (
    .Clk(Clk), .Reset(Reset), .sample_tick(sample_tick), .keycode(keycode),
    .sram_addr(sram_addr), .sram_oe(sram_oe), .sram_data(sram_data),
    .audio_data(audio_data), .audio_valid(audio_valid), .voice_active(voice_active),
    .busy(busy), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] word_at(input logic [19:0] a, input int mode, input logic [15:0] cw);
    logic [31:0] h;
    if (mode != 0) return cw;
    h = {12'd0, a} * 32'h9E3779B1;
    return h[31:16] ^ h[15:0];
  endfunction

  always @(*) sram_data = word_at(sram_addr, sram_mode, const_word);

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_key[i] = 0; m_off[i] = 0; m_act[i] = 0;
    end
    m_ovr = 0;
  endtask

  task automatic model_step(input logic [NV*KW-1:0] kc);
    int sum, k, a;
    logic signed [15:0] sw;
    exp_addr.delete();
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      k = int'(kc[i*KW +: KW]);
      if (k == 0) begin
        m_key[i] = 0; m_off[i] = 0; m_act[i] = 0;
      end else if (k != m_key[i]) begin
        m_key[i] = k; m_off[i] = 0; m_act[i] = 1;
      end
    end
    for (int i = 0; i < NV; i++) begin
      if (m_act[i]) begin
        a = (m_key[i] * (1 << RS) + m_off[i]) % (1 << AW);
        exp_addr.push_back(a);
        sw = word_at(20'(a), sram_mode, const_word);
        sum += sw;
        if (m_off[i] == NL-1) begin
          m_off[i] = 0;
`ifndef VOICE_LOOP_EN
          m_act[i] = 0;
`endif
        end else begin
          m_off[i]++;
        end
      end
    end
    if (sum > 32767)  sum = 32767;
    if (sum < -32768) sum = -32768;
    exp_data = sum & 32'hFFFF;
    exp_a    = exp_addr.size();
  endtask

  function automatic logic [NV-1:0] model_active();
    logic [NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i] = m_act[i];
    return v;
  endfunction

  // Issues one tick from an IDLE cycle and follows it cycle by cycle to the IDLE cycle after DONE.
  task automatic run_tick(input int chg_at, input logic [NV*KW-1:0] chg_kc, input int ovr_at);
    int exp_lat, n_oe, idx, ovr;
    bit seen;
    model_step(keycode);
    exp_lat = 2 + exp_a * RL;
    ovr = (ovr_at > exp_lat) ? exp_lat : ovr_at;
    if (ovr > 0) m_ovr = 1;
    n_oe = 0; seen = 0; obs_lat = -1; obs_data = -1; obs_first_addr = -1;
    sample_tick = 1'b1;
    @(negedge Clk);
    for (int k = 1; k <= exp_lat + 4 && !seen; k++) begin
      sample_tick = (k == ovr);
      if (k == chg_at) keycode = chg_kc;
      #1;
      if (sram_oe) begin
        idx = (k - 2) / RL;
        if (obs_first_addr < 0) obs_first_addr = int'(sram_addr);
        if (k >= 2 && idx < exp_a) check_val("sram_addr", sram_addr, exp_addr[idx]);
        else check_val("sram_oe_stray", sram_oe, 0);
        n_oe++;
      end
      if (k == 1) check_val("busy_scan", busy, 1);
      if (audio_valid) begin
        seen = 1; obs_lat = k; obs_data = int'(audio_data);
        check_val("busy_done", busy, 1);
      end
      @(negedge Clk);
    end
    sample_tick = 1'b0;
    #1;
    check_val("idle_busy", busy, 0);
    check_val("idle_valid", audio_valid, 0);
    check_val("latency", obs_lat, exp_lat);
    check_val("oe_cycles", n_oe, exp_a * RL);
    check_val("audio_data", obs_data, exp_data);
    check_val("voice_active", voice_active, model_active());
    check_val("overrun", overrun, m_ovr);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_audio"}, audio_data, 0);
    check_val({tag, "_valid"}, audio_valid, 0);
    check_val({tag, "_addr"}, sram_addr, 0);
    check_val({tag, "_oe"}, sram_oe, 0);
    check_val({tag, "_active"}, voice_active, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; sample_tick = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NV*KW-1:0] kc;
    int r, chg_at, ovr_at;

    model_reset();
    repeat (3) @(negedge Clk);
    #1;
    check_all_zero("por");
    @(negedge Clk);
    Reset = 1'b0;
    #1;

    keycode = '0;
    run_tick(0, '0, 0);
    check_val("silent_lat", obs_lat, 2);
    check_val("silent_data", obs_data, 0);

    keycode = 32'h0000_0005;
    run_tick(0, '0, 0);
    check_val("single_addr0", obs_first_addr, 32'h05000);
    check_val("single_lat", obs_lat, 4);
    check_val("single_data", obs_data, word_at(20'h05000, 0, 16'h0));
    run_tick(0, '0, 0);
    check_val("single_addr1", obs_first_addr, 32'h05001);

    apply_reset();
    keycode = {8'd2, 8'd3, 8'd4, 8'd5};
    sram_mode = 1; const_word = 16'h7000;
    run_tick(0, '0, 0);
    check_val("sat_pos", obs_data, 16'h7FFF);
    check_val("sat_first_addr", obs_first_addr, 32'h05000);
    check_val("four_voice_lat", obs_lat, 10);
    const_word = 16'h9000;
    run_tick(0, '0, 0);
    check_val("sat_neg", obs_data, 16'h8000);
    sram_mode = 0;

    apply_reset();
    keycode = 32'h0000_0005;
    repeat (10) run_tick(0, '0, 0);
    keycode = 32'h0000_0002;
    run_tick(0, '0, 0);
    check_val("key_change_addr", obs_first_addr, 32'h02000);
    keycode = '0;
    run_tick(0, '0, 0);
    check_val("key_off_active", voice_active[0], 0);
    check_val("key_off_lat", obs_lat, 2);

    keycode = 32'h0403_0201;
    run_tick(0, '0, 5);
    check_val("ovr_flag", overrun, 1);

    apply_reset();
    keycode = 32'h0000_0005;
    repeat (3) run_tick(0, '0, 0);
    sample_tick = 1'b1;
    @(negedge Clk); sample_tick = 1'b0;
    @(negedge Clk); sample_tick = 1'b1;
    @(negedge Clk); sample_tick = 1'b0;
    #1;
    check_val("midfetch_oe", sram_oe, 1);
    check_val("midfetch_ovr", overrun, 1);
    Reset = 1'b1;
    #1;
    check_all_zero("midfetch_rst");
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    #1;
    run_tick(0, '0, 0);
    check_val("after_rst_addr", obs_first_addr, 32'h05000);

    apply_reset();
    for (int n = 0; n < 300; n++) begin
      kc = keycode;
      for (int i = 0; i < NV; i++) begin
        r = $urandom_range(0, 9);
        if (r >= 6 && r < 8) kc[i*KW +: KW] = '0;
        else if (r >= 8)     kc[i*KW +: KW] = KW'($urandom_range(1, 6));
      end
      keycode = kc;
      r = $urandom_range(0, 9);
      sram_mode = (r < 3) ? 1 : 0;
      const_word = (r == 0) ? 16'h7000 : (r == 1) ? 16'h9000 : 16'($urandom);
      chg_at = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 4) : 0;
      ovr_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 12) : 0;
      run_tick(chg_at, NV*KW'($urandom), ovr_at);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      #1;
    end
    sram_mode = 0;

    apply_reset();
    keycode = 32'h0000_0005;
    repeat (NL) run_tick(0, '0, 0);
    run_tick(0, '0, 0);
`ifdef VOICE_LOOP_EN
    check_val("note_wrap_addr", obs_first_addr, 32'h05000);
    check_val("note_wrap_active", voice_active[0], 1);
`else
    check_val("note_end_lat", obs_lat, 2);
    check_val("note_end_data", obs_data, 0);
    check_val("note_end_active", voice_active[0], 0);
    repeat (2) run_tick(0, '0, 0);
    check_val("note_end_held", voice_active[0], 0);
`endif
    keycode = '0;
    run_tick(0, '0, 0);
    keycode = 32'h0000_0005;
    run_tick(0, '0, 0);
    check_val("repress_addr", obs_first_addr, 32'h05000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
